// File: rtl/picosoc_busmux.sv
// rtl/picosoc_busmux.sv - PicoRV32 native-port address decoder and registered response mux
// Define PICOSOC_BUSMUX_TIMEOUT_EN to force an error response on slaves that stall in BUSY.
module picosoc_busmux #(
  parameter int                         NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = {4{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK     = {4{32'h0}},
  parameter int                         TIMEOUT_CYCLES = 255,
  parameter logic [31:0]                ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic [31:0]              mem_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  output logic                     bus_err,
  output logic [31:0]              err_addr
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sel;
  logic             err_flag;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             sel_ready;
  logic [31:0]      sel_rdata;
  logic             timeout;

  assign s_addr  = mem_addr;
  assign s_wdata = mem_wdata;
  assign s_wstrb = mem_wstrb;

  // Scanning downward lets the lowest matching index overwrite any higher one.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((mem_addr & SLAVE_MASK[32*i +: 32]) == (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32])) begin
        hit     = 1'b1;
        hit_idx = i[IDX_W-1:0];
      end
    end
  end

  assign sel_ready = s_ready[sel];
  assign sel_rdata = s_rdata[sel*32 +: 32];

`ifdef PICOSOC_BUSMUX_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tcnt;

  assign timeout = (tcnt == TO_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcnt <= '0;
    end else if (state == IDLE) begin
      tcnt <= '0;
    end else if (state == BUSY) begin
      tcnt <= tcnt + 16'd1;
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dropping mem_valid in BUSY is an abort and takes priority over a late s_ready.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          state_nxt = hit ? BUSY : RESP;
        end
      end
      BUSY: begin
        if (!mem_valid) begin
          state_nxt = IDLE;
        end else if (sel_ready || timeout) begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (state == RESP);
    bus_err   = (state == RESP) && err_flag;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      s_valid[i] = (state == BUSY) && (sel == i[IDX_W-1:0]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel       <= '0;
      err_flag  <= 1'b0;
      mem_rdata <= '0;
      err_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid) begin
            if (hit) begin
              sel      <= hit_idx;
              err_flag <= 1'b0;
            end else begin
              err_flag  <= 1'b1;
              mem_rdata <= ERR_RDATA;
              err_addr  <= mem_addr;
            end
          end
        end
        BUSY: begin
          if (mem_valid) begin
            if (sel_ready) begin
              mem_rdata <= sel_rdata;
            end else if (timeout) begin
              err_flag  <= 1'b1;
              mem_rdata <= ERR_RDATA;
              err_addr  <= mem_addr;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_picosoc_busmux.sv
// tb/tb_picosoc_busmux.sv - randomized bench for picosoc_busmux against a transaction-level model
// Timeout scenarios run only when PICOSOC_BUSMUX_TIMEOUT_EN is defined.
module tb_picosoc_busmux;

  localparam int          NS   = 2;
  localparam int          TO   = 8;
  localparam logic [31:0] ERRW = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic [1:0]  s_valid;
  logic [1:0]  s_ready;
  logic [63:0] s_rdata;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        bus_err;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] base_tab [NS] = '{32'h0000_0000, 32'h0200_0000};
  logic [31:0] mask_tab [NS] = '{32'hFFFF_F000, 32'hFFFF_FFF0};
  logic [31:0] last_err = 32'h0;

  picosoc_busmux #(
    .NUM_SLAVES     (NS),
    .SLAVE_BASE     ({32'h0200_0000, 32'h0000_0000}),
    .SLAVE_MASK     ({32'hFFFF_FFF0, 32'hFFFF_F000}),
    .TIMEOUT_CYCLES (TO),
    .ERR_RDATA      (ERRW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .bus_err   (bus_err),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int target_of(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & mask_tab[i]) == (base_tab[i] & mask_tab[i])) return i;
    end
    return -1;
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ready"}, {31'b0, mem_ready}, 32'h0);
    check_eq({tag, "_svalid"}, {30'b0, s_valid}, 32'h0);
    check_eq({tag, "_err"}, {31'b0, bus_err}, 32'h0);
  endtask

  // Called at a negedge; k is the cycle in which the target slave raises s_ready.
  task automatic run_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            input int k, input logic [31:0] rd0, input logic [31:0] rd1);
    int          tgt;
    int          resp;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [1:0]  exp_sv;
    tgt = target_of(a);
    if (tgt < 0) begin
      resp = 1;
      exp_err = 1'b1;
    end else begin
`ifdef PICOSOC_BUSMUX_TIMEOUT_EN
      exp_err = (k > TO);
      resp    = exp_err ? TO + 1 : k + 1;
`else
      exp_err = 1'b0;
      resp    = k + 1;
`endif
    end
    exp_rd = exp_err ? ERRW : ((tgt == 1) ? rd1 : rd0);
    exp_sv = (tgt >= 0) ? 2'(1 << tgt) : 2'b00;
    if (exp_err) last_err = a;
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    s_rdata   = {rd1, rd0};
    s_ready   = 2'b00;
    for (int c = 1; c <= resp; c++) begin
      @(negedge clk);
      check_eq("s_addr", s_addr, a);
      check_eq("s_wdata", s_wdata, wd);
      check_eq("s_wstrb", {28'b0, s_wstrb}, {28'b0, ws});
      if (c < resp) begin
        check_eq("busy_ready", {31'b0, mem_ready}, 32'h0);
        check_eq("busy_svalid", {30'b0, s_valid}, {30'b0, exp_sv});
        s_ready = 2'($urandom_range(0, 3));
        if (tgt >= 0) s_ready[tgt] = (c == k);
      end else begin
        check_eq("resp_ready", {31'b0, mem_ready}, 32'h1);
        check_eq("resp_svalid", {30'b0, s_valid}, 32'h0);
        check_eq("resp_err", {31'b0, bus_err}, {31'b0, exp_err});
        check_eq("resp_rdata", mem_rdata, exp_rd);
        check_eq("resp_erraddr", err_addr, last_err);
        s_ready = 2'b00;
      end
    end
    // CPU sees mem_ready on the next edge, so the request stays up through it.
    @(negedge clk);
    mem_valid = 1'b0;
    check_quiet("post1");
    @(negedge clk);
    check_quiet("post2");
  endtask

  task automatic run_abort(input logic [31:0] a, input int j);
    int         tgt;
    logic [1:0] exp_sv;
    tgt = target_of(a);
    exp_sv = 2'(1 << tgt);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wstrb = 4'h0;
    for (int c = 1; c <= j; c++) begin
      @(negedge clk);
      check_eq("abort_svalid", {30'b0, s_valid}, {30'b0, exp_sv});
      s_ready = 2'b00;
    end
    mem_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_quiet("abort_after");
    end
  endtask

  function automatic logic [31:0] rand_addr(input int cls);
    case (cls)
      0:       return {20'h0, 12'($urandom_range(0, 4095))};
      1:       return {28'h020_0000, 4'($urandom_range(0, 15))};
      default: return 32'h0300_0000 | {8'h0, 24'($urandom)};
    endcase
  endfunction

  initial begin
    int k;
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    s_ready   = '0;
    s_rdata   = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check_eq("reset_rdata", mem_rdata, 32'h0);
    check_eq("reset_erraddr", err_addr, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    run_access(32'h0000_0010, 32'h0, 4'h0, 1, 32'h1234_5678, 32'hAAAA_5555);
    run_access(32'h0200_0004, 32'hCAFE_F00D, 4'b0011, 5, 32'h1111_1111, 32'h2222_2222);
    run_access(32'h0300_0000, 32'h0, 4'h0, 1, 32'h3333_3333, 32'h4444_4444);
`ifdef PICOSOC_BUSMUX_TIMEOUT_EN
    run_access(32'h0200_0008, 32'h0, 4'h0, 1000, 32'h5555_5555, 32'h6666_6666);
    run_access(32'h0200_000C, 32'h0, 4'h0, TO, 32'h7777_7777, 32'h8888_8888);
`endif

    for (int n = 0; n < 40; n++) begin
`ifdef PICOSOC_BUSMUX_TIMEOUT_EN
      k = $urandom_range(1, 12);
`else
      k = $urandom_range(1, 10);
`endif
      run_access(rand_addr($urandom_range(0, 2)), $urandom, 4'($urandom_range(0, 15)), k, $urandom, $urandom);
    end

    run_abort(32'h0000_0100, 1);
    run_abort(32'h0200_0002, 4);

    mem_valid = 1'b1;
    mem_addr  = 32'h0200_0008;
    mem_wstrb = 4'h0;
    @(negedge clk);
    check_eq("pre_reset_svalid", {30'b0, s_valid}, 32'h2);
    resetn = 1'b0;
    #1;
    check_quiet("async_reset");
    check_eq("async_reset_rdata", mem_rdata, 32'h0);
    check_eq("async_reset_erraddr", err_addr, 32'h0);
    last_err = 32'h0;
    for (int c = 0; c < 3; c++) begin
      s_ready = {c[0] == 1'b0, 1'b0};
      @(negedge clk);
      check_quiet("in_reset");
      check_eq("in_reset_rdata", mem_rdata, 32'h0);
    end
    s_ready = 2'b00;
    resetn  = 1'b1;
    run_access(32'h0200_0008, 32'h0, 4'h0, 2, 32'h9999_0000, 32'hBEEF_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
